// File: rtl/mio_bus_gen.sv
// rtl/mio_bus_gen.sv - memory-mapped I/O interconnect with request/ack handshake
// Decodes a slave index from the address and returns bus errors on unmapped or silent slaves.
module mio_bus_gen #(
  parameter int NSLV    = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SEL_LO  = 12,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      m_addr,
  input  logic [DW-1:0]      m_wdata,
  input  logic               m_we,
  input  logic               m_re,
  output logic [DW-1:0]      m_rdata,
  output logic               m_ready,
  output logic               m_err,
  output logic [7:0]         err_cnt,
  output logic [NSLV-1:0]    s_sel,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  output logic               s_we,
  output logic               s_re,
  input  logic [NSLV*DW-1:0] s_rdata,
  input  logic [NSLV-1:0]    s_ack
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [SEL_W:0] LP_NSLV = NSLV[SEL_W:0];
  localparam logic [CW-1:0]  LP_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [SEL_W-1:0] w_idx;
  logic            w_req;
  logic            w_hit;
  logic            w_ack;
  logic            w_tmo;
  logic [NSLV-1:0] w_dec;
  logic [DW-1:0]   w_rdata;

  assign w_idx   = m_addr[SEL_LO +: SEL_W];
  assign w_req   = m_we | m_re;
  assign w_hit   = ({1'b0, w_idx} < LP_NSLV);
  assign w_tmo   = (r_cnt == LP_LAST);
  assign m_ready = (r_state == DONE);

  // s_sel is one-hot, so ack and read data are simple AND-OR selects on it.
  always_comb begin
    w_dec   = '0;
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_dec[i] = ({1'b0, w_idx} == (SEL_W+1)'(i));
      if (s_sel[i]) begin
        w_ack   = w_ack | s_ack[i];
        w_rdata = w_rdata | s_rdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_hit ? ACCESS : DONE;
      ACCESS:  if (w_ack || w_tmo) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_re    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            if (w_hit) begin
              s_sel <= w_dec;
              s_we  <= m_we;
              s_re  <= m_re & ~m_we;
            end else begin
              m_err   <= 1'b1;
              m_rdata <= '0;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // Ack has priority over a timeout landing in the same cycle.
          if (w_ack) begin
            m_rdata <= s_re ? w_rdata : '0;
            m_err   <= 1'b0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
          end else if (w_tmo) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_gen.sv
// tb/tb_mio_bus_gen.sv - directed self-checking bench for mio_bus_gen
module tb_mio_bus_gen;

  logic         clk;
  logic         rst;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_we;
  logic         m_re;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic [7:0]   err_cnt;
  logic [3:0]   s_sel;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_we;
  logic         s_re;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;

  int checks = 0;
  int failures = 0;

  mio_bus_gen dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .err_cnt(err_cnt),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_addr = '0; m_wdata = '0; m_we = 0; m_re = 0; s_rdata = '0; s_ack = '0;
    step(); step();
    checks++; if ({s_sel, s_we, s_re, m_ready, m_err} !== 8'h00) begin failures++; $display("FAIL reset_ctl: got %b expected 00000000", {s_sel, s_we, s_re, m_ready, m_err}); end
    checks++; if ({s_addr, s_wdata, m_rdata, err_cnt} !== 104'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", {s_addr, s_wdata, m_rdata, err_cnt}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_immediate();
    m_re = 1; m_addr = 32'h0000_2004; s_rdata[2*32 +: 32] = 32'hDEADBEEF;
    step();
    checks++; if ({s_sel, s_re, s_we, m_ready} !== 7'b0100_1_0_0) begin failures++; $display("FAIL rd_access: got %b expected 0100100", {s_sel, s_re, s_we, m_ready}); end
    s_ack = 4'b0100;
    step();
    checks++; if ({m_ready, m_err, m_rdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_done: got %b %b %h expected 1 0 deadbeef", m_ready, m_err, m_rdata); end
    checks++; if ({s_sel, s_re} !== 5'b0) begin failures++; $display("FAIL rd_strobe_drop: got %b expected 0", {s_sel, s_re}); end
    m_re = 0; s_ack = '0;
    step();
    checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rd_pulse: got %b expected 0", m_ready); end
  endtask

  task automatic test_write_wait();
    m_we = 1; m_addr = 32'h0000_1010; m_wdata = 32'h55;
    step();
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({s_sel, s_we, s_re, m_ready, s_wdata, s_addr} !== {4'b0010, 3'b100, 32'h55, 32'h1010}) begin
        failures++; $display("FAIL wr_hold%0d: got %b %h %h expected 0010100 55 1010", k, {s_sel, s_we, s_re, m_ready}, s_wdata, s_addr);
      end
      if (k == 4) s_ack = 4'b0010;
      step();
    end
    checks++; if ({m_ready, m_err, m_rdata, err_cnt} !== {2'b10, 32'h0, 8'd0}) begin failures++; $display("FAIL wr_done: got %b %b %h %0d expected 1 0 0 0", m_ready, m_err, m_rdata, err_cnt); end
    m_we = 0; s_ack = '0;
    step();
  endtask

  task automatic test_unmapped();
    m_re = 1; m_addr = 32'h0000_7000;
    step();
    checks++; if ({s_sel, s_re, s_we} !== 6'b0) begin failures++; $display("FAIL unm_strobe: got %b expected 0", {s_sel, s_re, s_we}); end
    checks++; if ({m_ready, m_err, m_rdata, err_cnt} !== {2'b11, 32'h0, 8'd1}) begin failures++; $display("FAIL unm_done: got %b %b %h %0d expected 1 1 0 1", m_ready, m_err, m_rdata, err_cnt); end
    m_re = 0;
    step();
  endtask

  task automatic test_timeout();
    int cycles;
    m_re = 1; m_addr = 32'h0000_0000; s_rdata[0 +: 32] = 32'h1234_5678;
    step();
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_ready) break;
      if (s_re && s_sel == 4'b0001) cycles++;
      step();
    end
    checks++; if (cycles !== 15) begin failures++; $display("FAIL tmo_cycles: got %0d expected 15", cycles); end
    checks++; if ({m_ready, m_err, m_rdata, err_cnt} !== {2'b11, 32'h0, 8'd2}) begin failures++; $display("FAIL tmo_done: got %b %b %h %0d expected 1 1 0 2", m_ready, m_err, m_rdata, err_cnt); end
    m_re = 0;
    step();
    m_re = 1; s_rdata[0 +: 32] = 32'hCAFE_0000;
    step();
    for (int i = 0; i < 14; i++) step();
    checks++; if ({m_ready, s_re} !== 2'b01) begin failures++; $display("FAIL tmo_last_cycle: got %b expected 01", {m_ready, s_re}); end
    s_ack = 4'b0001;
    step();
    checks++; if ({m_ready, m_err, m_rdata, err_cnt} !== {2'b10, 32'hCAFE_0000, 8'd2}) begin failures++; $display("FAIL tmo_ack_wins: got %b %b %h %0d expected 1 0 cafe0000 2", m_ready, m_err, m_rdata, err_cnt); end
    m_re = 0; s_ack = '0;
    step();
  endtask

  task automatic test_we_re_stray();
    m_we = 1; m_re = 1; m_addr = 32'h0000_0000; m_wdata = 32'hAA;
    s_rdata[3*32 +: 32] = 32'h3333_3333;
    step();
    checks++; if ({s_sel, s_we, s_re} !== 6'b0001_10) begin failures++; $display("FAIL both_strobe: got %b expected 000110", {s_sel, s_we, s_re}); end
    s_ack = 4'b1000;
    step();
    checks++; if ({m_ready, s_we} !== 2'b01) begin failures++; $display("FAIL stray_ack: got %b expected 01", {m_ready, s_we}); end
    s_ack = 4'b0001;
    step();
    checks++; if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL both_done: got %b %b %h expected 1 0 0", m_ready, m_err, m_rdata); end
    m_we = 0; m_re = 0; s_ack = '0;
    step();
  endtask

  task automatic test_reset_abort();
    int seen;
    m_re = 1; m_addr = 32'h0000_2000;
    step(); step();
    checks++; if ({s_sel, s_re} !== 5'b0100_1) begin failures++; $display("FAIL abort_pre: got %b expected 01001", {s_sel, s_re}); end
    rst = 1;
    step();
    checks++; if ({s_sel, s_re, s_we, m_ready, err_cnt} !== 15'b0) begin failures++; $display("FAIL abort_reset: got %b %0d expected 0 0", {s_sel, s_re, s_we, m_ready}, err_cnt); end
    rst = 0; m_re = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_ready) seen++;
      step();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_ready: got %0d expected 0", seen); end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    m_re = 1; m_addr = 32'h0000_7000;
    for (int i = 0; i < 700 && pulses < 300; i++) begin
      step();
      if (m_ready) begin
        pulses++;
        if (pulses == 254) begin
          checks++; if (err_cnt !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d expected 254", err_cnt); end
        end
      end
    end
    m_re = 0;
    checks++; if (pulses !== 300) begin failures++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_255: got %0d expected 255", err_cnt); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_we_re_stray();
    test_reset_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_bus_gen.md
Name: mio_bus_gen

Overview:
- Parametrised memory-mapped I/O interconnect between the single-cycle CPU data port and NSLV peripheral slaves: VGA RAM, PS/2, 7-seg, data RAM and future devices.
- Decodes a slave index from a configurable address field and runs a registered request/acknowledge handshake per transaction, so slow slaves can insert wait states.
- Returns bus errors for unmapped indices and for slaves that miss a cycle timeout, and keeps a saturating error count for debug display on the 7-seg.

Parameters:
- NSLV, 4, number of slave channels (1..16).
- DW, 32, data width.
- AW, 32, address width.
- SEL_LO, 12, low bit of the slave-index field in m_addr.
- SEL_W, 4, width of the slave-index field (2**SEL_W >= NSLV).
- TIMEOUT, 15, maximum ACCESS cycles before an error (>= 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- m_addr  in  AW  master address, held stable while a request is pending.
- m_wdata  in  DW  master write data.
- m_we  in  1  write request level.
- m_re  in  1  read request level.
- m_rdata  out  DW  read data, valid while m_ready=1.
- m_ready  out  1  one-cycle transaction-complete pulse.
- m_err  out  1  error flag, valid while m_ready=1.
- err_cnt  out  8  saturating count of errored transactions.
- s_sel  out  NSLV  one-hot slave select.
- s_addr  out  AW  registered address broadcast to all slaves.
- s_wdata  out  DW  registered write data broadcast.
- s_we  out  1  write strobe, qualified by s_sel.
- s_re  out  1  read strobe, qualified by s_sel.
- s_rdata  in  NSLV*DW  flattened slave read data; slave i occupies [i*DW +: DW].
- s_ack  in  NSLV  per-slave acknowledge; may be combinational within ACCESS.

Behaviour:
- Reset: state=IDLE. All outputs are 0: s_sel, s_we, s_re, s_addr, s_wdata, m_rdata, m_ready, m_err, err_cnt. The timeout counter is 0. A reset during ACCESS aborts the transaction with no m_ready pulse, and all strobes drop on the reset edge.
- idx = m_addr[SEL_LO +: SEL_W], sampled in IDLE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, request present (m_we or m_re):
  - Latch m_addr and m_wdata into s_addr and s_wdata.
  - If m_we and m_re are both set, the transaction is a write only.
  - If idx < NSLV: go to ACCESS with s_sel[idx]=1 and s_we/s_re registered.
  - If idx >= NSLV: go to DONE with m_err=1, m_rdata=0, no strobes, err_cnt+1.
- ACCESS:
  - Strobes are held and the counter increments each cycle.
  - If s_ack[idx]=1: m_rdata <= s_rdata slice idx on a read, or 0 on a write; go to DONE with m_err=0.
  - Else if counter == TIMEOUT-1: go to DONE with m_err=1, m_rdata=0, err_cnt+1.
  - Acks on non-selected channels are ignored.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE:
  - m_ready=1 for exactly one cycle; strobes and s_sel are 0; the counter clears.
  - Incoming requests are ignored; next state is IDLE.
  - The master must drop or replace its request at the edge where m_ready=1. Otherwise it is re-issued as a new transaction from IDLE.
- m_rdata and m_err hold their value until the next DONE. m_ready is the only pulse output.
- Latency, request to m_ready high:
  - Ack in the first ACCESS cycle: 2 cycles.
  - An ack after n wait cycles adds n cycles.
  - Decode error: 1 cycle.
  - Timeout: TIMEOUT+1 cycles.
- err_cnt saturates at 255 and never wraps. Only rst clears it.
- Writes to the strobes are single transactions; there is no pipelining and at most one outstanding transaction.

Test Plan:
- Read, slave 2 acks immediately: m_re=1, m_addr=0x0000_2004, s_rdata slice2=0xDEADBEEF -> s_sel=0b0100 and s_re=1 for one cycle; m_ready 2 cycles after the request with m_rdata=0xDEADBEEF, m_err=0.
- Write with wait states: m_we=1, m_addr=0x0000_1010, m_wdata=0x55; slave 1 acks on its 4th ACCESS cycle -> s_we, s_wdata=0x55 and s_addr=0x1010 held for 4 cycles; m_ready=1, m_err=0; err_cnt unchanged.
- Unmapped index: m_re with idx=7 and NSLV=4 -> no s_sel bit set; m_ready after 1 cycle, m_err=1, m_rdata=0; err_cnt=1.
- Timeout: slave 0 never acks, TIMEOUT=15 -> strobes held for exactly 15 cycles; then m_ready with m_err=1. Also check ack and timeout in the same cycle -> m_err=0.
- Simultaneous m_we and m_re -> only s_we asserted and m_rdata=0. A stray ack on slave 3 while slave 0 is selected -> ignored.
- Reset and saturation:
  - Assert rst on the 2nd ACCESS cycle -> strobes 0 next edge, no m_ready, err_cnt=0.
  - Then 300 decode errors -> err_cnt=255.
